// File: rtl/off_chip_rx_deframer_if.sv
// Bundle of link-side and downstream-side signals for the off-chip receive deframer.
// Optional parity signals are present only when RX_PARITY_EN is defined.
interface off_chip_rx_deframer_if;
    logic [15:0] link_data;
    logic        link_valid;
    logic        link_credit;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready;
    logic        overflow_err;
`ifdef RX_PARITY_EN
    logic        link_parity;
    logic        parity_err;
`endif

`ifdef RX_PARITY_EN
    modport master (
        output link_data, link_valid, link_parity, ready,
        input  link_credit, data_out, valid_out, overflow_err, parity_err
    );
    modport slave (
        input  link_data, link_valid, link_parity, ready,
        output link_credit, data_out, valid_out, overflow_err, parity_err
    );
`else
    modport master (
        output link_data, link_valid, ready,
        input  link_credit, data_out, valid_out, overflow_err
    );
    modport slave (
        input  link_data, link_valid, ready,
        output link_credit, data_out, valid_out, overflow_err
    );
`endif
endinterface

// File: rtl/off_chip_rx_deframer.sv
// Receive deframer: gathers four 16-bit beats into a 64-bit word, buffers words in a
// DEPTH-entry FIFO, and returns one credit per freed slot. Optional feature: RX_PARITY_EN.
module off_chip_rx_deframer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    off_chip_rx_deframer_if.slave bus
);

    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        BEAT3 = 2'd3
    } beat_state_e;

    localparam logic [AW:0] FULL_C = DEPTH[AW:0];

    beat_state_e           state_q, state_d;
    logic [2:0][15:0]      beats_q, beats_d;
    logic [63:0]           mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;
    logic [AW:0]           pending_q, pending_d;
    logic [AW:0]           remain_s;
    logic [63:0]           data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  link_credit_q, link_credit_d;
    logic                  overflow_q, overflow_d;
    logic                  bad_q, bad_d;
    logic                  parity_err_q, parity_err_d;
    logic [63:0]           word_s, head_s;
    logic                  word_done_s, word_bad_s, beat_bad_s;
    logic                  pop_s, push_s, drop_s, full_s;

    // Even parity over the beat payload and its parity bit; returns 1 on a bad beat.
    function automatic logic parity_bad(input logic [15:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    // Beat FSM, beat collection and parity marking.
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        bad_d      = bad_q;
`ifdef RX_PARITY_EN
        beat_bad_s = parity_bad(bus.link_data, bus.link_parity);
`else
        beat_bad_s = 1'b0;
`endif
        if (bus.link_valid) begin
            case (state_q)
                BEAT0: begin
                    beats_d[0] = bus.link_data;
                    state_d    = BEAT1;
                end
                BEAT1: begin
                    beats_d[1] = bus.link_data;
                    state_d    = BEAT2;
                end
                BEAT2: begin
                    beats_d[2] = bus.link_data;
                    state_d    = BEAT3;
                end
                BEAT3: begin
                    state_d    = BEAT0;
                end
                default: begin
                    state_d    = BEAT0;
                end
            endcase
            if (state_q == BEAT0) begin
                bad_d = beat_bad_s;
            end else begin
                bad_d = bad_q | beat_bad_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Word assembly: upper byte of beat k is byte 4+k, lower byte is byte k.
    always_comb begin
        word_s = {bus.link_data[15:8], beats_q[2][15:8], beats_q[1][15:8], beats_q[0][15:8],
                  bus.link_data[7:0],  beats_q[2][7:0],  beats_q[1][7:0],  beats_q[0][7:0]};
        word_done_s = bus.link_valid && (state_q == BEAT3);
        word_bad_s  = word_done_s && (bad_q || beat_bad_s);
    end

    // FIFO control, output head register, credits and sticky error flags.
    always_comb begin
        pop_s    = valid_out_q & bus.ready;
        full_s   = (count_q == FULL_C);
        push_s   = word_done_s & ~word_bad_s & (~full_s | pop_s);
        drop_s   = word_done_s & ~push_s;
        wptr_d   = wptr_q + {{(AW-1){1'b0}}, push_s};
        rptr_d   = rptr_q + {{(AW-1){1'b0}}, pop_s};
        count_d  = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        remain_s = count_q - {{AW{1'b0}}, pop_s};
        // With nothing left behind the popped word, the new head is the word being pushed.
        if (remain_s == {(AW+1){1'b0}}) begin
            head_s = word_s;
        end else begin
            head_s = mem_q[rptr_d];
        end
        valid_out_d = (count_d != {(AW+1){1'b0}});
        if (valid_out_d) begin
            data_out_d = head_s;
        end else begin
            data_out_d = data_out_q;
        end
        link_credit_d = (pending_q != {(AW+1){1'b0}});
        pending_d     = pending_q + {{AW{1'b0}}, pop_s} + {{AW{1'b0}}, drop_s}
                        - {{AW{1'b0}}, link_credit_d};
        overflow_d    = overflow_q | (word_done_s & ~word_bad_s & full_s & ~pop_s);
        parity_err_d  = parity_err_q | word_bad_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BEAT0;
            beats_q       <= '0;
            bad_q         <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            pending_q     <= '0;
            data_out_q    <= 64'd0;
            valid_out_q   <= 1'b0;
            link_credit_q <= 1'b0;
            overflow_q    <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            bad_q         <= bad_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            link_credit_q <= link_credit_d;
            overflow_q    <= overflow_d;
            parity_err_q  <= parity_err_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= word_s;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.link_credit  = link_credit_q;
    assign bus.overflow_err = overflow_q;
`ifdef RX_PARITY_EN
    assign bus.parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_off_chip_rx_deframer.sv
// Directed bench for off_chip_rx_deframer: hand-computed words, FIFO ordering,
// overflow, credit counting and mid-word reset.
module tb_off_chip_rx_deframer;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;
    int   credit_cnt;
    logic [63:0] popped_q[$];
    logic [63:0] w [10];

    off_chip_rx_deframer_if bus ();

    off_chip_rx_deframer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Credit pulses and accepted words, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.link_credit) credit_cnt++;
        if (!rst && bus.valid_out && bus.ready) popped_q.push_back(bus.data_out);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] beat_of(input logic [63:0] wd, input int k);
        return {wd[32+8*k +: 8], wd[8*k +: 8]};
    endfunction

    // Sends beats first..last of a word; bad_beat selects a beat with wrong parity (-1 none).
    task automatic send_beats(input logic [63:0] wd, input int first, input int last,
                              input int gap, input int bad_beat);
        for (int k = first; k <= last; k++) begin
            bus.link_data  = beat_of(wd, k);
`ifdef RX_PARITY_EN
            bus.link_parity = (^beat_of(wd, k)) ^ (k == bad_beat);
`endif
            bus.link_valid = 1'b1;
            tick();
            bus.link_valid = 1'b0;
            if (k < 3) repeat (gap) tick();
        end
    endtask

    int c0;

    initial begin
        chk_cnt = 0; pass_cnt = 0; credit_cnt = 0;
        for (int i = 0; i < 10; i++) w[i] = 64'hA5A5_0000_0000_0000 | (64'(i) << 32) | 64'(i * 32'h1111_1111);
        bus.link_data = 16'h0000; bus.link_valid = 1'b0; bus.ready = 1'b0;
`ifdef RX_PARITY_EN
        bus.link_parity = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_valid", 64'(bus.valid_out), 64'd0);
        check_eq("rst_data", bus.data_out, 64'd0);
        check_eq("rst_credit", 64'(bus.link_credit), 64'd0);
        check_eq("rst_ovf", 64'(bus.overflow_err), 64'd0);
`ifdef RX_PARITY_EN
        check_eq("rst_perr", 64'(bus.parity_err), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Back-to-back beats, ready high.
        bus.ready = 1'b1;
        c0 = credit_cnt;
        send_beats(64'h0123_4567_89AB_CDEF, 0, 3, 0, -1);
        check_eq("b2b_valid", 64'(bus.valid_out), 64'd1);
        check_eq("b2b_data", bus.data_out, 64'h0123_4567_89AB_CDEF);
        repeat (5) tick();
        check_eq("b2b_credit", 64'(credit_cnt - c0), 64'd1);
        check_eq("b2b_empty", 64'(bus.valid_out), 64'd0);

        // Idle gaps between beats.
        c0 = credit_cnt;
        send_beats(64'h0123_4567_89AB_CDEF, 0, 2, 3, -1);
        repeat (3) tick();
        check_eq("gap_novalid", 64'(bus.valid_out), 64'd0);
        check_eq("gap_nocredit", 64'(credit_cnt - c0), 64'd0);
        send_beats(64'h0123_4567_89AB_CDEF, 3, 3, 0, -1);
        check_eq("gap_data", bus.data_out, 64'h0123_4567_89AB_CDEF);
        repeat (5) tick();
        check_eq("gap_credit", 64'(credit_cnt - c0), 64'd1);

        // Fill 8 with ready low, then drain in 8 consecutive cycles.
        bus.ready = 1'b0;
        c0 = credit_cnt;
        for (int i = 0; i < 8; i++) send_beats(w[i], 0, 3, 0, -1);
        repeat (3) tick();
        check_eq("fill_valid", 64'(bus.valid_out), 64'd1);
        check_eq("fill_head", bus.data_out, w[0]);
        check_eq("fill_nocredit", 64'(credit_cnt - c0), 64'd0);
        popped_q.delete();
        bus.ready = 1'b1;
        repeat (8) tick();
        check_eq("drain_count", 64'(popped_q.size()), 64'd8);
        check_eq("drain_empty", 64'(bus.valid_out), 64'd0);
        for (int i = 0; i < 8 && i < popped_q.size(); i++) check_eq($sformatf("drain_w%0d", i), popped_q[i], w[i]);
        repeat (5) tick();
        check_eq("drain_credits", 64'(credit_cnt - c0), 64'd8);

        // Full FIFO, 9th word completes in the same cycle as a pop.
        bus.ready = 1'b0;
        c0 = credit_cnt;
        for (int i = 0; i < 8; i++) send_beats(w[i], 0, 3, 0, -1);
        send_beats(w[9], 0, 2, 0, -1);
        popped_q.delete();
        bus.ready = 1'b1;
        send_beats(w[9], 3, 3, 0, -1);
        check_eq("pp_noovf", 64'(bus.overflow_err), 64'd0);
        repeat (10) tick();
        check_eq("pp_count", 64'(popped_q.size()), 64'd9);
        if (popped_q.size() == 9) check_eq("pp_last", popped_q[8], w[9]);
        check_eq("pp_credits", 64'(credit_cnt - c0), 64'd9);

        // Full FIFO without a pop: 9th word dropped, one credit, sticky overflow.
        bus.ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beats(w[i], 0, 3, 0, -1);
        repeat (4) tick();
        c0 = credit_cnt;
        send_beats(w[8], 0, 3, 0, -1);
        check_eq("ovf_flag", 64'(bus.overflow_err), 64'd1);
        repeat (5) tick();
        check_eq("ovf_credit", 64'(credit_cnt - c0), 64'd1);
        check_eq("ovf_head", bus.data_out, w[0]);
        popped_q.delete();
        bus.ready = 1'b1;
        repeat (12) tick();
        check_eq("ovf_drain_count", 64'(popped_q.size()), 64'd8);
        if (popped_q.size() == 8) check_eq("ovf_drain_last", popped_q[7], w[7]);
        check_eq("ovf_sticky", 64'(bus.overflow_err), 64'd1);
        check_eq("ovf_credits", 64'(credit_cnt - c0), 64'd9);

        // Reset mid-word with a word stored, then a fresh word.
        bus.ready = 1'b0;
        send_beats(w[1], 0, 3, 0, -1);
        send_beats(w[2], 0, 1, 0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_valid", 64'(bus.valid_out), 64'd0);
        check_eq("mrst_ovf", 64'(bus.overflow_err), 64'd0);
        tick();
        c0 = credit_cnt;
        bus.ready = 1'b1;
        send_beats(w[3], 0, 3, 0, -1);
        check_eq("mrst_data", bus.data_out, w[3]);
        repeat (5) tick();
        check_eq("mrst_credit", 64'(credit_cnt - c0), 64'd1);

`ifdef RX_PARITY_EN
        c0 = credit_cnt;
        send_beats(w[4], 0, 3, 0, 2);
        check_eq("par_nopush", 64'(bus.valid_out), 64'd0);
        check_eq("par_err", 64'(bus.parity_err), 64'd1);
        repeat (5) tick();
        check_eq("par_credit", 64'(credit_cnt - c0), 64'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
